bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the core's memory bus, using the req/done handshake with we, adr, dat and byteNr. Master 0 is the riscv core; master 1 is a secondary bus master such as DMA or a debug port. The arbiter sits between the masters and the memory/peripheral slave. It grants one master at a time and routes that master's request to the slave. It also returns an error-terminated done if the slave never answers.

---
 rtl/bus_arbiter.sv | 127 ++++++++++++
 tb/tb_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master, one-slave memory bus arbiter with a req/done handshake.
// Grants one master at a time and terminates silent slave accesses with an error.
module bus_arbiter #(
    parameter bit          FAIR    = 1'b1,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [2:0]  m0_byteNr_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_done_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [2:0]  m1_byteNr_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_done_o,
    output logic        m1_err_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [2:0]  s_byteNr_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_done_i,
    output logic [1:0]  gnt_o
);

    localparam logic [1:0]  IDLE         = 2'd0;
    localparam logic [1:0]  GRANT0       = 2'd1;
    localparam logic [1:0]  GRANT1       = 2'd2;
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        last;
    logic [15:0] cnt;
    logic        granted;
    logic        sel;
    logic        cur_req;
    logic        timeout_fire;
    logic        finish;

    assign granted = (state == GRANT0) || (state == GRANT1);
    assign sel     = (state == GRANT1);
    assign cur_req = sel ? m1_req_i : m0_req_i;

    // An abandoned request gets no done, so the timeout only fires while the master still asks.
    assign timeout_fire = (TIMEOUT != 16'd0) && granted && cur_req && !s_done_i
                          && (cnt == TIMEOUT_LAST);
    assign finish       = s_done_i || !cur_req || timeout_fire;

    // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_req_i && m1_req_i)
                    state_nxt = (FAIR && !last) ? GRANT1 : GRANT0;
                else if (m0_req_i)
                    state_nxt = GRANT0;
                else if (m1_req_i)
                    state_nxt = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (finish)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt != IDLE)
                last <= (state_nxt == GRANT1);
            cnt <= granted ? cnt + 16'd1 : 16'd0;
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = {state == GRANT1, state == GRANT0};

    always_comb begin
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = 32'd0;
        s_dat_o    = 32'd0;
        s_byteNr_o = 3'd0;
        m0_done_o  = 1'b0;
        m0_err_o   = 1'b0;
        m1_done_o  = 1'b0;
        m1_err_o   = 1'b0;
        if (granted) begin
            s_req_o = cur_req && !timeout_fire;
            if (sel) begin
                s_we_o     = m1_we_i;
                s_adr_o    = m1_adr_i;
                s_dat_o    = m1_dat_i;
                s_byteNr_o = m1_byteNr_i;
                m1_done_o  = s_done_i || timeout_fire;
                m1_err_o   = timeout_fire;
            end else begin
                s_we_o     = m0_we_i;
                s_adr_o    = m0_adr_i;
                s_dat_o    = m0_dat_i;
                s_byteNr_o = m0_byteNr_i;
                m0_done_o  = s_done_i || timeout_fire;
                m0_err_o   = timeout_fire;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a round-robin instance with TIMEOUT=4 and a fixed-priority
// instance with the timeout disabled share one stimulus and are compared to a transaction model.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_adr = '0, m1_adr = '0, m0_dat = '0, m1_dat = '0, s_dat = '0;
    logic [2:0]  m0_byte = 3'd4, m1_byte = 3'd4;
    logic        s_done = 1'b0;

    logic [1:0]  gnt_w [2];
    logic        sreq_w [2], swe_w [2];
    logic [31:0] sadr_w [2], sdat_w [2], m0dat_w [2], m1dat_w [2];
    logic [2:0]  sbyte_w [2];
    logic        m0done_w [2], m1done_w [2], m0err_w [2], m1err_w [2];

    int checks = 0;
    int errors = 0;

    // Per-instance configuration of the model: index 0 = round-robin, 1 = fixed priority.
    int fair_k [2] = '{1, 0};
    int to_k   [2] = '{4, 0};

    // Model state: owner -1 means nobody holds the bus; age counts granted cycles so far.
    int owner [2], age [2], lastw [2];
    int n_owner [2], n_age [2], n_last [2];
    logic [1:0]  e_gnt [2];
    logic        e_sreq [2];
    logic [67:0] e_mux [2];
    logic [1:0]  e_done [2], e_err [2];

    always #5 clk = ~clk;

    bus_arbiter #(.FAIR(1'b1), .TIMEOUT(16'd4)) u_fair (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_byteNr_i(m0_byte), .m0_dat_o(m0dat_w[0]), .m0_done_o(m0done_w[0]), .m0_err_o(m0err_w[0]),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_byteNr_i(m1_byte), .m1_dat_o(m1dat_w[0]), .m1_done_o(m1done_w[0]), .m1_err_o(m1err_w[0]),
        .s_req_o(sreq_w[0]), .s_we_o(swe_w[0]), .s_adr_o(sadr_w[0]), .s_dat_o(sdat_w[0]),
        .s_byteNr_o(sbyte_w[0]), .s_dat_i(s_dat), .s_done_i(s_done), .gnt_o(gnt_w[0])
    );

    bus_arbiter #(.FAIR(1'b0), .TIMEOUT(16'd0)) u_fixed (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_byteNr_i(m0_byte), .m0_dat_o(m0dat_w[1]), .m0_done_o(m0done_w[1]), .m0_err_o(m0err_w[1]),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_byteNr_i(m1_byte), .m1_dat_o(m1dat_w[1]), .m1_done_o(m1done_w[1]), .m1_err_o(m1err_w[1]),
        .s_req_o(sreq_w[1]), .s_we_o(swe_w[1]), .s_adr_o(sadr_w[1]), .s_dat_o(sdat_w[1]),
        .s_byteNr_o(sbyte_w[1]), .s_dat_i(s_dat), .s_done_i(s_done), .gnt_o(gnt_w[1])
    );

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1;
            age[k]   = 0;
            lastw[k] = 1;
        end
    endtask

    // Expected outputs for the current inputs plus the owner for the next cycle.
    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            int  w;
            bit  req, fire;
            e_gnt[k]  = 2'b00;
            e_sreq[k] = 1'b0;
            e_mux[k]  = '0;
            e_done[k] = 2'b00;
            e_err[k]  = 2'b00;
            n_last[k] = lastw[k];
            if (owner[k] < 0) begin
                if (m0_req && m1_req) w = (fair_k[k] != 0) ? 1 - lastw[k] : 0;
                else if (m0_req)      w = 0;
                else if (m1_req)      w = 1;
                else                  w = -1;
                n_owner[k] = w;
                n_age[k]   = 0;
                if (w >= 0) n_last[k] = w;
            end else begin
                req  = (owner[k] == 1) ? m1_req : m0_req;
                fire = (to_k[k] != 0) && (age[k] == to_k[k] - 1) && !s_done && req;
                e_gnt[k]  = (owner[k] == 1) ? 2'b10 : 2'b01;
                e_sreq[k] = req && !fire;
                e_mux[k]  = (owner[k] == 1) ? {m1_we, m1_adr, m1_dat, m1_byte}
                                            : {m0_we, m0_adr, m0_dat, m0_byte};
                e_done[k][owner[k]] = s_done || fire;
                e_err[k][owner[k]]  = fire;
                n_owner[k] = (s_done || !req || fire) ? -1 : owner[k];
                n_age[k]   = (age[k] + 1) % 65536;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d_gnt", k), 68'(gnt_w[k]), 68'(e_gnt[k]));
            check($sformatf("u%0d_s_req", k), 68'(sreq_w[k]), 68'(e_sreq[k]));
            check($sformatf("u%0d_s_bus", k), {swe_w[k], sadr_w[k], sdat_w[k], sbyte_w[k]}, e_mux[k]);
            check($sformatf("u%0d_done", k), 68'({m1done_w[k], m0done_w[k]}), 68'(e_done[k]));
            check($sformatf("u%0d_err", k), 68'({m1err_w[k], m0err_w[k]}), 68'(e_err[k]));
            check($sformatf("u%0d_rdata", k), 68'({m1dat_w[k], m0dat_w[k]}), 68'({s_dat, s_dat}));
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
        check_all();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                owner[k] = n_owner[k];
                age[k]   = n_age[k];
                lastw[k] = n_last[k];
            end
        end
        #1;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic reset_now();
        #2 rst = 1'b1;
        #1;
        model_reset();
        model_eval();
        check_all();
    endtask

    logic [1:0] fair_seq  [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [1:0] fixed_seq [8] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};

    initial begin
        #1;
        model_reset();
        model_eval();
        check_all();
        tick();
        tick();
        rst = 1'b0;

        // Ties with a zero-wait slave: alternation vs. master 0 always winning.
        m0_req = 1'b1; m1_req = 1'b1; s_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample();
            check("tie_fair_gnt", 68'(gnt_w[0]), 68'(fair_seq[i]));
            check("tie_fixed_gnt", 68'(gnt_w[1]), 68'(fixed_seq[i]));
            tick();
        end
        m0_req = 1'b0;
        step();
        sample();
        check("fixed_m1_after_m0_drop", 68'(gnt_w[1]), 68'(2'b10));
        tick();
        m1_req = 1'b0; s_done = 1'b0;
        step();

        // Single master-0 read of 0x100, slave answers on the third granted cycle.
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h100; m0_byte = 3'd4;
        step();
        sample();
        check("rd_gnt", 68'(gnt_w[0]), 68'(2'b01));
        check("rd_adr", 68'(sadr_w[0]), 68'(32'h100));
        tick();
        step();
        s_done = 1'b1; s_dat = 32'hDEAD_BEEF;
        sample();
        check("rd_done", 68'({m1done_w[0], m0done_w[0]}), 68'(2'b01));
        check("rd_data", 68'(m0dat_w[0]), 68'(32'hDEAD_BEEF));
        tick();
        m0_req = 1'b0; s_done = 1'b0;
        sample();
        check("rd_idle", 68'(gnt_w[0]), 68'(2'b00));
        tick();

        // Master-1 write against a silent slave.
        m1_req = 1'b1; m1_we = 1'b1; m1_adr = 32'h2000; m1_dat = 32'h1234_5678; m1_byte = 3'd2;
        for (int i = 0; i < 4; i++) step();
        sample();
        check("to_done_err", 68'({m1done_w[0], m1err_w[0]}), 68'(2'b11));
        check("to_s_req", 68'(sreq_w[0]), 68'(1'b0));
        tick();
        sample();
        check("to_idle", 68'(gnt_w[0]), 68'(2'b00));
        tick();
        s_done = 1'b1;
        sample();
        check("to_retry_ok", 68'({m1done_w[0], m1err_w[0]}), 68'(2'b10));
        tick();
        m1_req = 1'b0; s_done = 1'b0;
        step();
        step();

        // Slave done lands on the same cycle the timeout would fire.
        m0_req = 1'b1;
        for (int i = 0; i < 4; i++) step();
        s_done = 1'b1;
        sample();
        check("coincide_done_err", 68'({m0done_w[0], m0err_w[0]}), 68'(2'b10));
        tick();
        m0_req = 1'b0; s_done = 1'b0;
        step();

        // Reset while master 0 holds the bus with a stalled slave.
        m0_req = 1'b1;
        step();
        step();
        reset_now();
        check("rst_drop", 68'({sreq_w[0], gnt_w[0], m0done_w[0]}), 68'(4'b0000));
        tick();
        rst = 1'b0;
        m1_req = 1'b1;
        step();
        sample();
        check("rst_tie_fair", 68'(gnt_w[0]), 68'(2'b01));
        check("rst_tie_fixed", 68'(gnt_w[1]), 68'(2'b01));
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        step();

        // Random traffic including abandoned requests, idle dones and reset pulses.
        for (int i = 0; i < 600; i++) begin
            m0_req  = ($urandom_range(0, 3) != 0);
            m1_req  = ($urandom_range(0, 3) != 0);
            m0_we   = 1'($urandom);
            m1_we   = 1'($urandom);
            m0_adr  = $urandom;
            m1_adr  = $urandom;
            m0_dat  = $urandom;
            m1_dat  = $urandom;
            m0_byte = 3'(1 << $urandom_range(0, 2));
            m1_byte = 3'(1 << $urandom_range(0, 2));
            s_dat   = $urandom;
            s_done  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0) begin
                reset_now();
                tick();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
